// File: rtl/lucas_lehmer_ctrl_pkg.sv
// Shared definitions for the Lucas-Lehmer sequencer.
// State encoding, seed value and exponent-width helper.
package lucas_lehmer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SQ,
    RED,
    SUB,
    CHECK
  } ll_state_e;

  localparam int LL_SEED = 4;

  function automatic int exp_w(input int bw);
    return $clog2(bw + 1);
  endfunction

endpackage

// File: rtl/lucas_lehmer_ctrl_fold.sv
// One Mersenne fold step: x mod-ish 2^p-1 as low p bits plus the rest.
// Runtime exponent; result fits in p+1 bits for the operands used here.
module mersenne_fold #(
  parameter int BITWIDTH = 32,
  parameter int EXP_W    = 6
) (
  input  logic [2*BITWIDTH-1:0] x_i,
  input  logic [EXP_W-1:0]      p_i,
  output logic [BITWIDTH:0]     sum_o
);

  localparam int PW = 2 * BITWIDTH;
  localparam int SW = BITWIDTH + 1;

  logic [PW-1:0] mask;
  logic [PW-1:0] lo;
  logic [PW-1:0] hi;

  assign mask  = (PW'(1) << p_i) - PW'(1);
  assign lo    = x_i & mask;
  assign hi    = x_i >> p_i;
  assign sum_o = SW'(lo + hi);

endmodule

// File: rtl/square.sv
// Combinational squarer shared by the Lucas-Lehmer datapath.
// Full-width product, no truncation.
module square #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0]   a_i,
  output logic [2*BITWIDTH-1:0] sq_o
);

  localparam int PW = 2 * BITWIDTH;

  assign sq_o = PW'(a_i) * PW'(a_i);

endmodule

// File: rtl/lucas_lehmer_ctrl.sv
// Lucas-Lehmer test sequencer for M_p = 2^p - 1.
// Owns the squarer; three cycles per iteration (square, fold, fold+sub).
module lucas_lehmer_ctrl
  import lucas_lehmer_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int EXP_W    = exp_w(BITWIDTH)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [EXP_W-1:0]    exponent,
  output logic                ready,
  output logic                done,
  output logic                is_prime,
  output logic                err,
  output logic [BITWIDTH-1:0] residue
);

  localparam int PW = 2 * BITWIDTH;
  localparam int SW = BITWIDTH + 1;

  ll_state_e           state_q;
  logic [EXP_W-1:0]    p_q;
  logic [EXP_W-1:0]    count_q;
  logic [BITWIDTH-1:0] s_q;
  logic [BITWIDTH-1:0] s_d;
  logic [BITWIDTH-1:0] residue_q;
  logic [PW-1:0]       prod_q;
  logic [PW-1:0]       sq_w;
  logic [PW-1:0]       fold_in;
  logic [SW-1:0]       fold_w;
  logic [SW-1:0]       fold1_q;
  logic [SW-1:0]       mp;
  logic [SW-1:0]       v;
  logic [SW-1:0]       sv;
  logic                ready_q;
  logic                done_q;
  logic                prime_q;
  logic                err_q;

  square #(
    .BITWIDTH(BITWIDTH)
  ) u_square (
    .a_i (s_q),
    .sq_o(sq_w)
  );

  // Same fold unit serves RED (on prod) and SUB (on fold1).
  assign fold_in = (state_q == SUB) ? PW'(fold1_q) : prod_q;

  mersenne_fold #(
    .BITWIDTH(BITWIDTH),
    .EXP_W   (EXP_W)
  ) u_fold (
    .x_i  (fold_in),
    .p_i  (p_q),
    .sum_o(fold_w)
  );

  always_comb begin
    mp  = (SW'(1) << p_q) - SW'(1);
    v   = (fold_w == mp) ? '0 : fold_w;
    sv  = (v >= SW'(2)) ? v - SW'(2)
                        : v + mp - SW'(2);
    s_d = BITWIDTH'(sv);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      prime_q   <= 1'b0;
      err_q     <= 1'b0;
      residue_q <= '0;
      count_q   <= '0;
      p_q       <= '0;
      s_q       <= '0;
      prod_q    <= '0;
      fold1_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q       <= exponent;
            prime_q   <= 1'b0;
            err_q     <= 1'b0;
            residue_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= INIT;
          end
        end
        INIT: begin
          if (p_q < EXP_W'(2) ||
              p_q > EXP_W'(BITWIDTH)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (p_q == EXP_W'(2)) begin
            done_q  <= 1'b1;
            prime_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            s_q     <= BITWIDTH'(LL_SEED);
            count_q <= p_q - EXP_W'(2);
            state_q <= SQ;
          end
        end
        SQ: begin
          prod_q  <= sq_w;
          state_q <= RED;
        end
        RED: begin
          fold1_q <= fold_w;
          state_q <= SUB;
        end
        SUB: begin
          s_q     <= s_d;
          count_q <= count_q - EXP_W'(1);
          state_q <= (count_q == EXP_W'(1)) ? CHECK : SQ;
        end
        CHECK: begin
          residue_q <= s_q;
          prime_q   <= (s_q == '0);
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign is_prime = prime_q;
  assign err      = err_q;
  assign residue  = residue_q;

endmodule

// File: tb/tb_lucas_lehmer_ctrl.sv
// Self-checking bench for lucas_lehmer_ctrl.
// Reference model uses plain modular arithmetic on wide integers.
module tb_lucas_lehmer_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [5:0]  exponent;
  logic        ready;
  logic        done;
  logic        is_prime;
  logic        err;
  logic [31:0] residue;

  int errors = 0;
  int checks = 0;

  lucas_lehmer_ctrl #(
    .BITWIDTH(32)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .exponent (exponent),
    .ready    (ready),
    .done     (done),
    .is_prime (is_prime),
    .err      (err),
    .residue  (residue)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ll_res(input int p);
    logic [127:0] m;
    logic [127:0] s;
    m = (128'd1 << p) - 128'd1;
    s = 128'd4;
    for (int i = 0; i < p - 2; i++)
      s = (s * s + m - 128'd2) % m;
    return s[31:0];
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_p(input int p);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("ready_before_start", ready, 1);
    start    = 1'b1;
    exponent = 6'(p);
    step();
    start    = 1'b0;
    exponent = 6'($urandom);
  endtask

  task automatic finish_p(input int p, input int chain, input bit busy);
    int edges;
    int lat;
    bit bad;
    logic [31:0] r;
    edges = 1;
    bad   = (p < 2 || p > 32);
    lat   = (bad || p == 2) ? 2 : 3 * (p - 2) + 3;
    r     = (bad || p == 2) ? 32'd0 : ll_res(p);
    while (done !== 1'b1 && edges < 200) begin
      if (busy && edges == 4) begin
        start    = 1'b1;
        exponent = 6'd3;
      end else if (busy && edges == 5) begin
        start    = 1'b0;
        exponent = 6'd40;
      end
      step();
      edges++;
    end
    chk($sformatf("done_seen p=%0d", p), done, 1);
    chk($sformatf("latency p=%0d", p), edges, lat);
    chk($sformatf("err p=%0d", p), err, bad);
    chk($sformatf("is_prime p=%0d", p), is_prime, !bad && r == 0);
    chk($sformatf("residue p=%0d", p), residue, r);
    chk($sformatf("ready_with_done p=%0d", p), ready, 1);
    if (chain >= 0) begin
      start    = 1'b1;
      exponent = 6'(chain);
    end
    step();
    start = 1'b0;
    chk($sformatf("done_pulse p=%0d", p), done, 0);
    if (chain >= 0)
      chk("chain_accept", ready, 0);
  endtask

  initial begin
    int rp;
    int extra;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    exponent  = '0;
    repeat (2) step();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_prime", is_prime, 0);
    chk("rst_err", err, 0);
    chk("rst_residue", residue, 0);
    #3 sys_rst_n = 1'b1;
    step();

    start_p(3);
    finish_p(3, -1, 0);
    start_p(5);
    finish_p(5, -1, 0);
    start_p(11);
    finish_p(11, -1, 0);
    chk("p11_residue_const", residue, 32'd1736);
    start_p(31);
    finish_p(31, -1, 0);
    start_p(32);
    finish_p(32, -1, 0);
    start_p(1);
    finish_p(1, -1, 0);
    start_p(0);
    finish_p(0, -1, 0);
    start_p(33);
    finish_p(33, -1, 0);
    start_p(2);
    finish_p(2, -1, 0);

    // start re-pulsed while busy must be dropped
    start_p(7);
    finish_p(7, -1, 1);
    extra = 0;
    repeat (15) begin
      step();
      if (done === 1'b1) extra++;
    end
    chk("no_extra_done", extra, 0);
    chk("idle_after_busy", ready, 1);

    // back-to-back: next start presented in the done cycle
    start_p(5);
    finish_p(5, 13, 0);
    finish_p(13, -1, 0);

    // reset in the middle of p=13
    start_p(13);
    repeat (10) step();
    chk("busy_before_rst", ready, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_prime", is_prime, 0);
    chk("midrst_err", err, 0);
    chk("midrst_residue", residue, 0);
    #2 sys_rst_n = 1'b1;
    step();
    start_p(5);
    finish_p(5, -1, 0);

    for (int k = 0; k < 16; k++) begin
      rp = int'($urandom_range(0, 34));
      start_p(rp);
      finish_p(rp, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
